// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_driver
// Description : Drives a two-digit, time-multiplexed, active-low 7-segment
//               display from an 8-bit value. Each digit slot is preceded by
//               an all-off blanking slot to suppress ghosting. New values are
//               taken through a one-entry pending buffer and reach the
//               display only at frame boundaries, so a frame never tears.
// Ports       : i_clk          - clock, rising edge
//               i_rst          - synchronous active-high reset
//               i_value[7:0]   - value to show ([3:0] digit 0, [7:4] digit 1)
//               i_valid        - i_value offered, taken when o_ready is high
//               o_ready        - pending buffer empty
//               o_digitalTube  - segments {g,f,e,d,c,b,a}, 0 = lit
//               o_sel          - digit being driven (0 = low nibble)
// Option      : LEADING_ZERO_BLANK_EN - blank digit 1 when it is zero
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_driver #(
    parameter int DIGIT_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_value,
    input  logic       i_valid,
    output logic       o_ready,
    output logic [6:0] o_digitalTube,
    output logic       o_sel
);

    localparam int C_MAX_CYCLES = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
    localparam int CW           = $clog2(C_MAX_CYCLES + 1);

    localparam logic [CW-1:0] C_DIGIT_LAST = CW'(DIGIT_CYCLES - 1);
    localparam logic [CW-1:0] C_BLANK_LAST = (BLANK_CYCLES > 0) ? CW'(BLANK_CYCLES - 1) : '0;
    localparam logic [6:0]    C_SEG_OFF    = 7'h7F;

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    // With no blanking slot the scan starts directly in SHOW.
    localparam state_t C_STATE_RST = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt,   w_cnt_nxt;
    logic          w_sel_nxt;
    logic [7:0]    r_disp,  w_disp_nxt;
    logic [7:0]    r_pend,  w_pend_nxt;
    logic          w_ready_nxt;
    logic [6:0]    w_seg_nxt;
    logic [3:0]    w_nibble;
    logic          w_boundary;
    logic          w_accept;

    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    // Scan sequencing: slot counter only runs within a slot and restarts
    // on every state change.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CW'(1);
        w_sel_nxt   = o_sel;
        case (r_state)
            ST_BLANK: begin
                if (r_cnt == C_BLANK_LAST) begin
                    w_state_nxt = ST_SHOW;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                if (r_cnt == C_DIGIT_LAST) begin
                    w_state_nxt = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;
                    w_cnt_nxt   = '0;
                    w_sel_nxt   = ~o_sel;
                end
            end
        endcase
    end

    // Handshake and display update. The boundary is the last clock of the
    // digit-1 slot; an empty buffer on that clock lets an offered value
    // bypass straight into the display register.
    assign w_boundary = (r_state == ST_SHOW) && o_sel && (r_cnt == C_DIGIT_LAST);
    assign w_accept   = i_valid && o_ready;

    always_comb begin
        w_disp_nxt  = r_disp;
        w_pend_nxt  = r_pend;
        w_ready_nxt = o_ready;
        if (w_boundary) begin
            if (!o_ready) begin
                w_disp_nxt  = r_pend;
                w_ready_nxt = 1'b1;
            end else if (w_accept) begin
                w_disp_nxt  = i_value;
            end
        end else if (w_accept) begin
            w_pend_nxt  = i_value;
            w_ready_nxt = 1'b0;
        end
    end

    // Segment output is computed from next-cycle state so the registered
    // bus lines up with the state it belongs to.
    always_comb begin
        w_nibble  = w_sel_nxt ? w_disp_nxt[7:4] : w_disp_nxt[3:0];
        w_seg_nxt = C_SEG_OFF;
        if (w_state_nxt == ST_SHOW) begin
            w_seg_nxt = decode(w_nibble);
`ifdef LEADING_ZERO_BLANK_EN
            if (w_sel_nxt && (w_disp_nxt[7:4] == 4'h0)) begin
                w_seg_nxt = C_SEG_OFF;
            end
`endif
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= C_STATE_RST;
            r_cnt         <= '0;
            o_sel         <= 1'b0;
            o_digitalTube <= C_SEG_OFF;
            o_ready       <= 1'b1;
            r_disp        <= 8'h00;
            r_pend        <= 8'h00;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            o_sel         <= w_sel_nxt;
            o_digitalTube <= w_seg_nxt;
            o_ready       <= w_ready_nxt;
            r_disp        <= w_disp_nxt;
            r_pend        <= w_pend_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_scan_driver
// Description : Scoreboard bench for seg7_scan_driver. A frame-position
//               reference model predicts segment bus, digit select and
//               ready for every clock; a monitor compares each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

    localparam int D = 4;
    localparam int B = 2;
    localparam int F = 2 * (D + B);

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid = 1'b0;
    logic [7:0] value = 8'h00;
    logic       ready;
    logic [6:0] seg;
    logic       sel;

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .DIGIT_CYCLES(D),
        .BLANK_CYCLES(B)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_value      (value),
        .i_valid      (valid),
        .o_ready      (ready),
        .o_digitalTube(seg),
        .o_sel        (sel)
    );

    typedef struct {
        int         cyc;
        logic [6:0] seg;
        logic       sel;
        logic       rdy;
    } exp_t;

    exp_t q[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   edge_n  = 0;

    // Reference model: position within the frame, shown value, pending slot.
    int         m_p    = 0;
    logic [7:0] m_disp = 8'h00;
    logic [7:0] m_pend = 8'h00;
    bit         m_full = 1'b0;

    always @(posedge clk) edge_n <= edge_n + 1;

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        logic [6:0] tbl [16];
        tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return tbl[n];
    endfunction

    // Advance the model across one clock edge with the given inputs and
    // push what the DUT must show after that edge.
    function automatic void model_step(input bit r, input bit v, input logic [7:0] val);
        exp_t e;
        bit   acc;
        int   slot;
        if (r) begin
            m_p = 0; m_disp = 8'h00; m_full = 1'b0;
        end else begin
            acc = v && !m_full;
            if (m_p == F - 1) begin
                if (m_full) begin
                    m_disp = m_pend; m_full = 1'b0;
                end else if (acc) begin
                    m_disp = val;
                end
            end else if (acc) begin
                m_pend = val; m_full = 1'b1;
            end
            m_p = (m_p + 1) % F;
        end
        e.cyc = edge_n + 1;
        e.sel = (m_p >= D + B);
        e.rdy = !m_full;
        slot  = m_p % (D + B);
        if (slot < B)
            e.seg = 7'h7F;
        else if (e.sel) begin
            e.seg = seg_of(m_disp[7:4]);
`ifdef LEADING_ZERO_BLANK_EN
            if (m_disp[7:4] == 4'h0) e.seg = 7'h7F;
`endif
        end else
            e.seg = seg_of(m_disp[3:0]);
        q.push_back(e);
    endfunction

    task automatic step(input bit r, input bit v, input logic [7:0] val);
        @(posedge clk);
        #1;
        rst = r; valid = v; value = val;
        model_step(r, v, val);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
    endtask

    // Monitor: one scoreboard entry per clock.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #3;
            if (q.size() > 0 && q[0].cyc < edge_n) begin
                n_total++;
                $display("FAIL stale_entry cyc=%0d now=%0d", q[0].cyc, edge_n);
                void'(q.pop_front());
            end
            if (q.size() > 0 && q[0].cyc == edge_n) begin
                e = q.pop_front();
                n_total++;
                if (seg === e.seg) n_pass++;
                else $display("FAIL seg cyc=%0d got=%h exp=%h", e.cyc, seg, e.seg);
                n_total++;
                if (sel === e.sel) n_pass++;
                else $display("FAIL sel cyc=%0d got=%b exp=%b", e.cyc, sel, e.sel);
                n_total++;
                if (ready === e.rdy) n_pass++;
                else $display("FAIL ready cyc=%0d got=%b exp=%b", e.cyc, ready, e.rdy);
            end
        end
    end

    initial begin : stimulus
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        idle(2 * F);

        // Accept mid digit-0 slot; shown from next frame.
        while (m_p != B + 1) idle(1);
        step(1'b0, 1'b1, 8'hA5);
        idle(2 * F);

        // Accept exactly on the boundary with buffer empty: bypass.
        while (m_p != F - 1 || m_full) idle(1);
        step(1'b0, 1'b1, 8'h3C);
        idle(F + 3);

        // Held valid: first value latched, second only after the boundary.
        while (m_p != B || m_full) idle(1);
        step(1'b0, 1'b1, 8'h11);
        for (int i = 0; i < F + 4; i++) step(1'b0, 1'b1, 8'h22);
        idle(2 * F);

        // Reset during digit-1 slot with pending full.
        while (m_p != 1 || m_full) idle(1);
        step(1'b0, 1'b1, 8'h5A);
        while (m_p != 2 * B + D + 1) idle(1);
        step(1'b1, 1'b0, 8'h00);
        idle(F + 2);

        // Leading-zero digit 1.
        while (m_p != 1 || m_full) idle(1);
        step(1'b0, 1'b1, 8'h07);
        idle(2 * F);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 1500; i++)
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 2) == 0), 8'($urandom));
        idle(4);

        @(posedge clk);
        #5;
        n_total++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL drain left=%0d exp=0", q.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
